iotdf_sched: RTL and testbench

Round-robin job scheduler that shares one IOTDF filter datapath among NREQ sensor requesters. Each granted job owns the filter for exactly one round (8 records × 16 bytes = 128 bytes) with a fixed function code. The block gates the byte stream into the filter, holds `fn_sel` stable for the whole round, and returns filter results tagged with the owner's index. It sits between the sensor front-ends and the IOTDF instance; both share `clk` and `rst`.

---
 rtl/iotdf_pkg.sv | 30 +++
 rtl/iotdf_rr_arb.sv | 50 +++++
 rtl/iotdf_sched.sv | 174 +++++++++++++++++
 tb/tb_iotdf_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iotdf_pkg.sv
// Shared definitions for the IOTDF job scheduler: filter function codes,
// scheduler state encoding and round geometry.
package iotdf_pkg;

  // Filter function codes; 0 means "no job" and is never granted
  localparam logic [2:0] FN_NONE    = 3'd0;
  localparam logic [2:0] FN_MAX     = 3'd1;
  localparam logic [2:0] FN_MIN     = 3'd2;
  localparam logic [2:0] FN_AVG     = 3'd3;
  localparam logic [2:0] FN_EXTRACT = 3'd4;
  localparam logic [2:0] FN_EXCLUDE = 3'd5;
  localparam logic [2:0] FN_PEAKMAX = 3'd6;
  localparam logic [2:0] FN_PEAKMIN = 3'd7;

  // One round = ROUND_RECORDS records of RECORD_BYTES bytes each
  localparam int RECORD_BYTES  = 16;
  localparam int ROUND_RECORDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // A request is only worth granting when it carries a real function code
  function automatic logic fn_valid(input logic [2:0] fn);
    return fn != FN_NONE;
  endfunction

endpackage

// File: rtl/iotdf_rr_arb.sv
// Combinational winner selection over the eligible-requester mask.
// Default: round-robin, searching from last+1 and wrapping modulo NREQ.
// Build option IOTDF_SCHED_PRIO_EN: fixed priority, lowest eligible index wins,
// and the last input is ignored.
module iotdf_rr_arb
  import iotdf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  win
);

`ifdef IOTDF_SCHED_PRIO_EN
  // Priority mode keeps no history
  logic unused_last;
  assign unused_last = ^last;

  // Lowest eligible index wins
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && elig[i]) begin
        any = 1'b1;
        win = IDW'(i);
      end
    end
  end
`else
  // First eligible requester found walking forward from last+1
  always_comb begin
    logic [IDW-1:0] idx;
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/iotdf_sched.sv
// Round-robin job scheduler sharing one IOTDF filter among NREQ requesters.
// A granted job owns the filter for one 128-byte round with a fixed function
// code, then lingers DRAIN_CYC cycles so late filter results keep its tag.
// Build option IOTDF_SCHED_PRIO_EN selects fixed-priority arbitration
// (see iotdf_rr_arb).
module iotdf_sched
  import iotdf_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DRAIN_CYC = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_fn,
  output logic [NREQ-1:0]   gnt,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  input  logic              f_busy,
  input  logic              f_valid,
  input  logic [127:0]      f_out,
  output logic              f_in_en,
  output logic [7:0]        f_iot_in,
  output logic [2:0]        f_fn_sel,
  output logic              res_valid,
  output logic [127:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              job_done
);

  localparam int             DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);
  localparam logic [3:0]     LAST_BYTE  = 4'(RECORD_BYTES - 1);
  localparam logic [2:0]     LAST_REC   = 3'(ROUND_RECORDS - 1);

  sched_state_e    state;
  logic [IDW-1:0]  owner;
  logic [3:0]      byte_cnt;
  logic [2:0]      rec_cnt;
  logic [DCW-1:0]  drain_cnt;

  logic [NREQ-1:0] elig;
  logic            arb_any;
  logic [IDW-1:0]  arb_win;
  logic [IDW-1:0]  arb_last;
  logic [2:0]      win_fn;
  logic            accept;
  logic            drain_exit;

  // Eligible = requesting with a non-zero function code
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path can leave it unassigned and infer a latch.
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] & fn_valid(req_fn[3*i +: 3]);
    end
  end

  // Function code of the current arbitration winner
  always_comb begin
    win_fn = FN_NONE;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win == IDW'(i)) begin
        win_fn = req_fn[3*i +: 3];
      end
    end
  end

  iotdf_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .elig (elig),
    .last (arb_last),
    .any  (arb_any),
    .win  (arb_win)
  );

  // Byte path is combinational so the source sees backpressure the same cycle
  assign src_ready  = (state == ST_RUN) & ~f_busy;
  assign accept     = src_ready & src_valid;
  assign f_in_en    = accept;
  assign f_iot_in   = src_data;
  assign drain_exit = (state == ST_DRAIN) && (drain_cnt == '0);

`ifdef IOTDF_SCHED_PRIO_EN
  assign arb_last = '0;
`else
  logic [IDW-1:0] last_q;

  // Remember the most recently finished owner to rotate the search origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
    end else if (drain_exit) begin
      last_q <= owner;
    end
  end

  assign arb_last = last_q;
`endif

  // Scheduler FSM: grant, count one round of bytes, drain, release
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      gnt       <= '0;
      f_fn_sel  <= FN_NONE;
      byte_cnt  <= '0;
      rec_cnt   <= '0;
      drain_cnt <= '0;
      job_done  <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            owner    <= arb_win;
            gnt      <= NREQ'(1) << arb_win;
            f_fn_sel <= win_fn;
            byte_cnt <= '0;
            rec_cnt  <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == LAST_BYTE) begin
              rec_cnt <= rec_cnt + 3'd1;
              if (rec_cnt == LAST_REC) begin
                drain_cnt <= DRAIN_LOAD;
                state     <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            // f_fn_sel deliberately holds until the next grant
            job_done <= 1'b1;
            gnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag filter results with the owner while a job holds the filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if ((state != ST_IDLE) && f_valid) begin
      res_valid <= 1'b1;
      res_data  <= f_out;
      res_id    <= owner;
    end else begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iotdf_sched.sv
// Self-checking bench for iotdf_sched: directed scenarios (single job,
// fairness, fn=0 rejection, backpressure, stall with request drop, mid-job
// reset) plus randomized traffic, all checked against a job-level model that
// tracks grant owner, accepted-byte count and remaining drain cycles.
module tb_iotdf_sched;

  localparam int NREQ      = 4;
  localparam int DRAIN_CYC = 4;
  localparam int IDW       = 2;
  localparam int ROUND     = 128;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  localparam int MODE_RAND   = 0;
  localparam int MODE_DIRECT = 1;
  localparam int MODE_SINGLE = 2;
  localparam int MODE_BUSY16 = 3;
  localparam int MODE_STALL  = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_fn;
  logic [NREQ-1:0]   gnt;
  logic              src_valid;
  logic [7:0]        src_data;
  logic              src_ready;
  logic              f_busy;
  logic              f_valid;
  logic [127:0]      f_out;
  logic              f_in_en;
  logic [7:0]        f_iot_in;
  logic [2:0]        f_fn_sel;
  logic              res_valid;
  logic [127:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              job_done;

  iotdf_sched #(
    .NREQ      (NREQ),
    .DRAIN_CYC (DRAIN_CYC),
    .IDW       (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_fn    (req_fn),
    .gnt       (gnt),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .f_busy    (f_busy),
    .f_valid   (f_valid),
    .f_out     (f_out),
    .f_in_en   (f_in_en),
    .f_iot_in  (f_iot_in),
    .f_fn_sel  (f_fn_sel),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .job_done  (job_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_state, m_owner, m_bytes, m_left, m_last;
  logic [NREQ-1:0] e_gnt;
  logic [2:0]      e_fn_sel;
  logic            e_res_valid;
  logic [127:0]    e_res_data;
  logic [IDW-1:0]  e_res_id;
  logic            e_job_done;

  int              en_count, res_count, jobs_done, grants, target_grants;
  int              glog[$];
  logic [NREQ-1:0] prev_gnt;
  int              mode, stall_cnt;
  bit              busy_next, fv_used;
  logic [7:0]      fixed_data;
  logic [NREQ-1:0] pat_req;
  logic [3*NREQ-1:0] pat_fn;

  // Arbitration rule written directly from the requester list
  function automatic int pick(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] fn, input int last);
    int i;
`ifdef IOTDF_SCHED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      if (r[k] && fn[3*k +: 3] != 3'd0) return k;
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (r[i] && fn[3*i +: 3] != 3'd0) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_state     = M_IDLE;
    m_owner     = 0;
    m_bytes     = 0;
    m_left      = 0;
    m_last      = NREQ - 1;
    e_gnt       = '0;
    e_fn_sel    = 3'd0;
    e_res_valid = 1'b0;
    e_res_data  = '0;
    e_res_id    = '0;
    e_job_done  = 1'b0;
    prev_gnt    = '0;
    busy_next   = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_gnt", gnt, 0);
    check("rst_fn_sel", f_fn_sel, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_job_done", job_done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_f_in_en", f_in_en, 0);
  endtask

  // Drive this cycle's inputs (called at the falling edge)
  task automatic gen_inputs();
    if (mode == MODE_RAND) begin
      req       = NREQ'($urandom);
      req_fn    = (3*NREQ)'($urandom);
      src_valid = ($urandom % 4) != 0;
      f_busy    = ($urandom % 4) == 0;
      f_valid   = ($urandom % 5) == 0;
      src_data  = 8'($urandom);
    end else begin
      req       = (grants < target_grants) ? pat_req : '0;
      req_fn    = pat_fn;
      src_valid = 1'b1;
      f_busy    = 1'b0;
      f_valid   = 1'b0;
      src_data  = (mode == MODE_SINGLE) ? fixed_data : 8'($urandom);
      if (mode == MODE_SINGLE && m_state == M_RUN && m_bytes == 64 && !fv_used) begin
        f_valid = 1'b1;
        fv_used = 1'b1;
      end
      if (mode == MODE_BUSY16) f_busy = busy_next;
      if (mode == MODE_STALL && m_state == M_RUN && m_bytes == 40 && stall_cnt < 20) begin
        src_valid = 1'b0;
        stall_cnt++;
      end
    end
    f_out = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Check outputs for the current cycle, then advance the model across the edge
  task automatic tick();
    bit exp_rdy, acc;
    int w;
    #1;
    check("gnt", gnt, e_gnt);
    check("f_fn_sel", f_fn_sel, e_fn_sel);
    check("res_valid", res_valid, e_res_valid);
    check("res_data", res_data, e_res_data);
    check("res_id", res_id, e_res_id);
    check("job_done", job_done, e_job_done);
    exp_rdy = (m_state == M_RUN) && !f_busy;
    acc     = exp_rdy && src_valid;
    check("src_ready", src_ready, exp_rdy);
    check("f_in_en", f_in_en, acc);
    if (acc) check("f_iot_in", f_iot_in, src_data);

    if (f_in_en) en_count++;
    if (res_valid) res_count++;
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
      glog.push_back(w);
    end
    prev_gnt = gnt;

    e_job_done = 1'b0;
    if (m_state != M_IDLE && f_valid) begin
      e_res_valid = 1'b1;
      e_res_data  = f_out;
      e_res_id    = IDW'(m_owner);
    end else begin
      e_res_valid = 1'b0;
    end
    busy_next = 1'b0;
    case (m_state)
      M_IDLE: begin
        w = pick(req, req_fn, m_last);
        if (w >= 0) begin
          m_owner  = w;
          e_gnt    = NREQ'(1) << w;
          e_fn_sel = req_fn[3*w +: 3];
          m_bytes  = 0;
          en_count = 0;
          m_state  = M_RUN;
          grants++;
        end
      end
      M_RUN: begin
        if (acc) begin
          m_bytes++;
          if (mode == MODE_BUSY16 && m_bytes % 16 == 0) busy_next = 1'b1;
          if (m_bytes == ROUND) begin
            m_state = M_DRAIN;
            m_left  = DRAIN_CYC;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          e_job_done = 1'b1;
          e_gnt      = '0;
          m_last     = m_owner;
          m_state    = M_IDLE;
          jobs_done++;
          check("bytes_per_job", en_count, ROUND);
        end
      end
    endcase
    @(negedge clk);
  endtask

  // Run until n jobs complete or the cycle budget expires
  task automatic run(input int n, input int md, input int tgt);
    int c;
    mode          = md;
    target_grants = tgt;
    jobs_done     = 0;
    grants        = 0;
    c             = 0;
    while (jobs_done < n && c < n * 800 + 100) begin
      gen_inputs();
      tick();
      c++;
    end
    check("jobs_completed", jobs_done, n);
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    int got;
    check({tag, "_len"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < glog.size()) ? glog[i] : -1;
      check(tag, got, exp_q[i]);
    end
  endtask

  initial begin
    int c;
    rst = 1'b1;
    req = '0; req_fn = '0; src_valid = 1'b0; src_data = '0;
    f_busy = 1'b0; f_valid = 1'b0; f_out = '0;
    fixed_data = 8'h00; fv_used = 1'b0; stall_cnt = 0;
    pat_req = '0; pat_fn = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Fairness: all four requesting with fn=1 from reset
    glog.delete();
    pat_req = 4'b1111;
    pat_fn  = {3'd1, 3'd1, 3'd1, 3'd1};
    run(5, MODE_DIRECT, 5);
`ifdef IOTDF_SCHED_PRIO_EN
    check_order("order_fair", '{0, 0, 0, 0, 0});
`else
    check_order("order_fair", '{0, 1, 2, 3, 0});
`endif

    // Function code 0 is never granted
    glog.delete();
    pat_req = 4'b0011;
    pat_fn  = {3'd0, 3'd0, 3'd2, 3'd0};
    run(2, MODE_DIRECT, 2);
    check_order("order_fn0", '{1, 1});

    // Single job on requester 0, fn=3, constant bytes, one filter result
    glog.delete();
    res_count  = 0;
    fv_used    = 1'b0;
    fixed_data = 8'h11;
    pat_req    = 4'b0001;
    pat_fn     = {3'd0, 3'd0, 3'd0, 3'd3};
    run(1, MODE_SINGLE, 1);
    check("single_res_count", res_count, 1);
    check_order("order_single", '{0});

    // Backpressure after every 16th byte
    pat_req = 4'b0100;
    pat_fn  = {3'd0, 3'd5, 3'd0, 3'd0};
    run(1, MODE_BUSY16, 1);

    // 20-cycle source stall after byte 40, request dropped after grant
    stall_cnt = 0;
    pat_req   = 4'b1000;
    pat_fn    = {3'd7, 3'd0, 3'd0, 3'd0};
    run(1, MODE_STALL, 1);
    check("stall_cycles", stall_cnt, 20);

    // Randomized traffic
    run(12, MODE_RAND, 0);

    // Mid-job reset after byte 70
    mode = MODE_RAND;
    c = 0;
    while (!(m_state == M_RUN && m_bytes >= 70) && c < 2000) begin
      gen_inputs();
      tick();
      c++;
    end
    check("reached_byte70", (m_state == M_RUN && m_bytes >= 70), 1);
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(2, MODE_RAND, 0);

    // Quiet tail so the final job_done and idle state are observed
    pat_req = '0;
    run(0, MODE_DIRECT, 0);
    repeat (3) begin
      gen_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
